// File: rtl/softmax_normalizer_pkg.sv
// Shared definitions for the softmax normalizer: FSM encoding and FP32 constants.
package softmax_normalizer_pkg;

   typedef enum logic [1:0] {
      StAccum = 2'd0,
      StCalc  = 2'd1,
      StEmit  = 2'd2
   } state_e;

   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
   localparam logic [31:0] FP_ONE     = 32'h3f80_0000;
   localparam logic [31:0] FP_QNAN    = 32'h7fc0_0000;
   localparam int unsigned FP_EXP_MSB = 30;
   localparam int unsigned FP_EXP_LSB = 23;

endpackage

// File: rtl/fp_add.sv
// Combinational single-precision adder. Round to nearest even; zero/denormal inputs and
// underflowing results are flushed to zero.
module fp_add
   import softmax_normalizer_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o
);

   logic              swap;
   logic [31:0]       big;
   logic [31:0]       sml;
   logic [23:0]       big_m;
   logic [23:0]       sml_m;
   logic [7:0]        ediff;
   logic [53:0]       sml_sh;
   logic [26:0]       big_x;
   logic [26:0]       sml_x;
   logic [27:0]       raw;
   logic [26:0]       norm;
   logic [4:0]        lz;
   logic signed [9:0] exp_n;
   logic              rnd_up;
   logic [24:0]       mant_r;
   logic              a_inf, b_inf, a_nan, b_nan;

   // Order by magnitude, align the smaller operand, add/subtract, normalise and round
   always_comb begin
      swap   = b_i[30:0] > a_i[30:0];
      big    = swap ? b_i : a_i;
      sml    = swap ? a_i : b_i;
      big_m  = (big[30:23] != 8'd0) ? {1'b1, big[22:0]} : 24'd0;
      sml_m  = (sml[30:23] != 8'd0) ? {1'b1, sml[22:0]} : 24'd0;
      ediff  = big[30:23] - sml[30:23];
      big_x  = {big_m, 3'b000};
      sml_sh = {sml_m, 30'd0} >> ediff;
      // Three extra bits below the mantissa: guard, round, sticky
      if (ediff >= 8'd27) begin
         sml_x = {26'd0, |sml_m};
      end else begin
         sml_x = {sml_sh[53:28], sml_sh[27] | (|sml_sh[26:0])};
      end
      if (big[31] == sml[31]) begin
         raw = {1'b0, big_x} + {1'b0, sml_x};
      end else begin
         raw = {1'b0, big_x} - {1'b0, sml_x};
      end
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (raw[i]) lz = 5'(26 - i);
      end
      exp_n = $signed({2'b00, big[30:23]});
      if (raw[27]) begin
         norm  = {raw[27:2], raw[1] | raw[0]};
         exp_n = exp_n + 10'sd1;
      end else begin
         norm  = raw[26:0] << lz;
         exp_n = exp_n - $signed({5'd0, lz});
      end
      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[26:3]} + 25'(rnd_up);
      if (mant_r[24]) exp_n = exp_n + 10'sd1;

      if (raw == 28'd0) begin
         y_o = {big[31] & sml[31], 31'd0};
      end else if (exp_n <= 10'sd0) begin
         y_o = {big[31], 31'd0};
      end else if (exp_n >= 10'sd255) begin
         y_o = {big[31], 8'hff, 23'd0};
      end else begin
         y_o = {big[31], exp_n[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
      end

      a_nan = (a_i[30:23] == 8'hff) && (a_i[22:0] != 23'd0);
      b_nan = (b_i[30:23] == 8'hff) && (b_i[22:0] != 23'd0);
      a_inf = (a_i[30:23] == 8'hff) && (a_i[22:0] == 23'd0);
      b_inf = (b_i[30:23] == 8'hff) && (b_i[22:0] == 23'd0);
      if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) begin
         y_o = FP_QNAN;
      end else if (a_inf) begin
         y_o = a_i;
      end else if (b_inf) begin
         y_o = b_i;
      end
   end

endmodule

// File: rtl/fp_div.sv
// Combinational single-precision divider a_i / b_i. Round to nearest even; zero/denormal
// operands are treated as zero and underflowing results flush to zero.
module fp_div
   import softmax_normalizer_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o
);

   logic [49:0]       num;
   logic [49:0]       den;
   logic [26:0]       quot;
   logic              rem_nz;
   logic [23:0]       mant;
   logic              guard, sticky, rnd_up;
   logic [24:0]       mant_r;
   logic signed [9:0] exp_n;
   logic              sign;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   // Mantissa quotient with 26 extra fraction bits, then round and handle special operands
   always_comb begin
      sign   = a_i[31] ^ b_i[31];
      num    = {1'b1, a_i[22:0], 26'd0};
      den    = {26'd0, 1'b1, b_i[22:0]};
      quot   = 27'(num / den);
      rem_nz = (num % den) != 50'd0;
      exp_n  = $signed({2'b00, a_i[30:23]}) - $signed({2'b00, b_i[30:23]})
               + (quot[26] ? 10'sd127 : 10'sd126);
      // Quotient lies in [2^25, 2^27); pick the window that starts at the leading one
      if (quot[26]) begin
         mant   = quot[26:3];
         guard  = quot[2];
         sticky = (|quot[1:0]) | rem_nz;
      end else begin
         mant   = quot[25:2];
         guard  = quot[1];
         sticky = quot[0] | rem_nz;
      end
      rnd_up = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + 25'(rnd_up);
      if (mant_r[24]) exp_n = exp_n + 10'sd1;

      if (exp_n <= 10'sd0) begin
         y_o = {sign, 31'd0};
      end else if (exp_n >= 10'sd255) begin
         y_o = {sign, 8'hff, 23'd0};
      end else begin
         y_o = {sign, exp_n[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
      end

      a_zero = a_i[30:23] == 8'd0;
      b_zero = b_i[30:23] == 8'd0;
      a_nan  = (a_i[30:23] == 8'hff) && (a_i[22:0] != 23'd0);
      b_nan  = (b_i[30:23] == 8'hff) && (b_i[22:0] != 23'd0);
      a_inf  = (a_i[30:23] == 8'hff) && (a_i[22:0] == 23'd0);
      b_inf  = (b_i[30:23] == 8'hff) && (b_i[22:0] == 23'd0);
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
         y_o = FP_QNAN;
      end else if (a_inf || b_zero) begin
         y_o = {sign, 8'hff, 23'd0};
      end else if (a_zero || b_inf) begin
         y_o = {sign, 31'd0};
      end
   end

endmodule

// File: rtl/softmax_normalizer_fp_accumulator.sv
// Running single-precision sum: register plus adder, with synchronous clear and enable.
module softmax_normalizer_fp_accumulator
   import softmax_normalizer_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic [31:0] data_i,
   output logic [31:0] sum_o
);

   logic [31:0] sum_q;
   logic [31:0] sum_d;
   logic [31:0] sum_add;

   fp_add u_add (
      .a_i (sum_q),
      .b_i (data_i),
      .y_o (sum_add)
   );

   // Clear wins over accumulate
   always_comb begin
      sum_d = sum_q;
      if (clear_i) begin
         sum_d = FP_ZERO;
      end else if (en_i) begin
         sum_d = sum_add;
      end
   end

   // Sum register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= FP_ZERO;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/softmax_normalizer.sv
// Buffers one vector of e^x values, accumulates their sum, then streams value/sum out.
module softmax_normalizer
   import softmax_normalizer_pkg::*;
#(
   parameter int unsigned N_CLASSES = 4,
   parameter int unsigned IDX_W     = $clog2(N_CLASSES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             div_zero
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_CLASSES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      buf_q [N_CLASSES];
   logic             buf_we;
   logic             acc_en, acc_clear;
   logic [31:0]      sum;
   logic [31:0]      quot;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_data_q, out_data_d;
   logic [IDX_W-1:0] out_index_q, out_index_d;
   logic             out_last_q, out_last_d;
   logic             div_zero_q, div_zero_d;

   softmax_normalizer_fp_accumulator u_acc (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clear_i (acc_clear),
      .en_i    (acc_en),
      .data_i  (in_data),
      .sum_o   (sum)
   );

   fp_div u_div (
      .a_i (buf_q[idx_q]),
      .b_i (sum),
      .y_o (quot)
   );

   // Next-state and handshake decode
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      buf_we      = 1'b0;
      acc_en      = 1'b0;
      acc_clear   = 1'b0;
      in_ready    = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      div_zero_d  = div_zero_q;
      unique case (state_q)
         StAccum: begin
            in_ready = 1'b1;
            if (in_valid) begin
               buf_we = 1'b1;
               acc_en = 1'b1;
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = StCalc;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         StCalc: begin
            // A zero/denormal sum cannot be divided by; flag it for the whole vector
            if (sum[FP_EXP_MSB:FP_EXP_LSB] == 8'd0) begin
               out_data_d = FP_ZERO;
               div_zero_d = 1'b1;
            end else begin
               out_data_d = quot;
            end
            out_index_d = idx_q;
            out_last_d  = (idx_q == LastIdx);
            out_valid_d = 1'b1;
            state_d     = StEmit;
         end
         StEmit: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  idx_d      = '0;
                  acc_clear  = 1'b1;
                  div_zero_d = 1'b0;
                  state_d    = StAccum;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = StCalc;
               end
            end
         end
         default: state_d = StAccum;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAccum;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= FP_ZERO;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
         div_zero_q  <= div_zero_d;
      end
   end

   // Vector buffer; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      if (buf_we) buf_q[idx_q] <= in_data;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares them.
module tb_softmax_normalizer;
   import softmax_normalizer_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;

   typedef logic [31:0] vec_t [N];
   typedef struct packed {
      logic [31:0]   data;
      logic [IW-1:0] idx;
      logic          last;
      logic          dz;
   } resp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = 32'd0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_data;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic          div_zero;

   resp_t sb[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    acc_edge = 0;
   int    last_hs_edge = 0;

   softmax_normalizer #(
      .N_CLASSES (N),
      .IDX_W     (IW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // FP32 bit pattern to real (zero/denormal read as zero)
   function automatic real b2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Real to FP32, round to nearest even; used only where results are normal numbers
   function automatic logic [31:0] r2b(input real r);
      logic [63:0] d;
      int          e;
      logic [24:0] m;
      logic        up;
      if (r == 0.0) return 32'd0;
      d  = $realtobits(r);
      e  = int'(d[62:52]) - 1023 + 127;
      m  = {2'b01, d[51:29]};
      up = d[28] && ((|d[27:0]) || d[29]);
      m  = m + 25'(up);
      if (m[24]) begin
         e++;
         m = m >> 1;
      end
      return {d[63], e[7:0], m[22:0]};
   endfunction

   task automatic push_resp(input logic [31:0] data, input int idx, input logic dz);
      resp_t r;
      r.data = data;
      r.idx  = IW'(idx);
      r.last = (idx == N - 1);
      r.dz   = dz;
      sb.push_back(r);
   endtask

   // Reference: sequential single-precision sum, then each element divided by it
   task automatic expect_vec(input vec_t v);
      logic [31:0] s;
      logic        dz;
      s = 32'd0;
      for (int i = 0; i < N; i++) s = r2b(b2r(s) + b2r(v[i]));
      dz = (s[30:23] == 8'd0);
      for (int i = 0; i < N; i++) push_resp(dz ? 32'd0 : r2b(b2r(v[i]) / b2r(s)), i, dz);
   endtask

   function automatic logic [31:0] rand_val();
      return {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
   endfunction

   task automatic send_vec(input vec_t v, input bit keep_valid, input bit check_b2b);
      int n;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = v[i];
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready) begin
            chk("input_accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
         acc_edge = cyc + 1;
         if (check_b2b && i == 0) chk("b2b_first_accept_edge", acc_edge, last_hs_edge + 1);
         @(posedge clk);
         #1;
      end
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic drain(input bit rand_ready);
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 300) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b1;
      chk("drain_pending", sb.size(), 0);
   endtask

   task automatic wait_index(input int idx, input string name);
      int n;
      n = 0;
      while (!(out_valid && out_index == IW'(idx)) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, 32'(out_valid && out_index == IW'(idx)), 32'd1);
   endtask

   // Monitor: every output handshake is compared against the head of the scoreboard
   always @(negedge clk) begin
      resp_t e;
      if (rst_n && out_valid && out_ready) begin
         chk("in_ready_during_output", 32'(in_ready), 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h index %0d, required no output", out_data,
                     out_index);
         end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_index", 32'(out_index), 32'(e.idx));
            chk("out_last", 32'(out_last), 32'(e.last));
            chk("div_zero", 32'(div_zero), 32'(e.dz));
            if (e.last) last_hs_edge = cyc + 1;
         end
      end
   end

   initial begin
      vec_t v, w;

      // Reset values
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Four ones: each probability is 0.25; check CALC latency after final accept
      v = '{FP_ONE, FP_ONE, FP_ONE, FP_ONE};
      for (int i = 0; i < N; i++) push_resp(32'h3e80_0000, i, 1'b0);
      send_vec(v, 1'b0, 1'b0);
      chk("lat_calc_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_valid_second_edge", 32'(out_valid), 32'd1);
      drain(1'b0);

      // 1,2,3,2 -> 1/8, 2/8, 3/8, 2/8
      v = '{FP_ONE, 32'h4000_0000, 32'h4040_0000, 32'h4000_0000};
      push_resp(32'h3e00_0000, 0, 1'b0);
      push_resp(32'h3e80_0000, 1, 1'b0);
      push_resp(32'h3ec0_0000, 2, 1'b0);
      push_resp(32'h3e80_0000, 3, 1'b0);
      send_vec(v, 1'b0, 1'b0);
      drain(1'b0);

      // All-zero vector: zero outputs with div_zero, cleared after last handshake
      v = '{32'd0, 32'd0, 32'd0, 32'd0};
      for (int i = 0; i < N; i++) push_resp(32'd0, i, 1'b1);
      send_vec(v, 1'b0, 1'b0);
      drain(1'b0);
      chk("div_zero_cleared", 32'(div_zero), 32'd0);

      // Backpressure on index 1 with in_valid pulses that must not be consumed
      for (int i = 0; i < N; i++) v[i] = rand_val();
      expect_vec(v);
      send_vec(v, 1'b0, 1'b0);
      wait_index(1, "bp_reach_index1");
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         in_data  = rand_val();
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         if (sb.size() != 0) begin
            chk("bp_out_data", out_data, sb[0].data);
            chk("bp_out_index", 32'(out_index), 32'(sb[0].idx));
            chk("bp_out_last", 32'(out_last), 32'(sb[0].last));
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(1'b0);

      // Back-to-back vectors with in_valid held high across the output phase
      for (int i = 0; i < N; i++) begin
         v[i] = rand_val();
         w[i] = rand_val();
      end
      expect_vec(v);
      expect_vec(w);
      send_vec(v, 1'b1, 1'b0);
      send_vec(w, 1'b0, 1'b1);
      drain(1'b0);

      // Random vectors with random downstream stalls
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < N; i++) v[i] = rand_val();
         expect_vec(v);
         send_vec(v, 1'b0, 1'b0);
         drain(1'b1);
      end

      // Asynchronous reset while index 2 is waiting in EMIT
      for (int i = 0; i < N; i++) v[i] = rand_val();
      expect_vec(v);
      send_vec(v, 1'b0, 1'b0);
      wait_index(2, "rst_reach_index2");
      out_ready = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_out_index", 32'(out_index), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      v = '{FP_ONE, 32'h4000_0000, 32'h4040_0000, 32'h4000_0000};
      push_resp(32'h3e00_0000, 0, 1'b0);
      push_resp(32'h3e80_0000, 1, 1'b0);
      push_resp(32'h3ec0_0000, 2, 1'b0);
      push_resp(32'h3e80_0000, 3, 1'b0);
      send_vec(v, 1'b0, 1'b0);
      drain(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
